// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer. Each beat goes to the channel named by select_i.
// Each channel has its own small in-order FIFO, so a stalled consumer only blocks its own channel.
module stream_demux_1to2 #(
  parameter int size  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data0_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [size-1:0]  data1_o,
  output logic [CNT_W-1:0] count0_o,
  output logic [CNT_W-1:0] count1_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [1:0]                 full;
  logic [1:0]                 empty;
  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0]                 cons_ready;
  logic [1:0][size-1:0]       head;
  logic [1:0][CNT_W-1:0]      cnt_all;

  assign cons_ready = {ready1_i, ready0_i};

  // ready_o must not depend on the consumer readies, only on the FIFO state.
  assign ready_o = ~full[select_i];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [size-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [CNT_W-1:0] cnt;

    assign full[c]  = (occ == OCC_FULL);
    assign empty[c] = (occ == '0);
    assign push[c]  = valid_i & ~full[c] & (select_i == 1'(c));
    assign pop[c]   = ~empty[c] & cons_ready[c];
    assign head[c]    = mem[rd_ptr];
    assign cnt_all[c] = cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        cnt    <= '0;
      end else begin
        if (push[c]) begin
          mem[wr_ptr] <= data_i;
          wr_ptr      <= wr_ptr + 1'b1;
          cnt         <= cnt + 1'b1;
        end
        if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

  assign valid0_o = ~empty[0];
  assign valid1_o = ~empty[1];
  assign data0_o  = head[0];
  assign data1_o  = head[1];
  assign count0_o = cnt_all[0];
  assign count1_o = cnt_all[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 with DEPTH=2 and 4-bit counters.
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_stream_demux_1to2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        select_i;
  logic        valid0_o;
  logic        ready0_i;
  logic [31:0] data0_o;
  logic        valid1_o;
  logic        ready1_i;
  logic [31:0] data1_o;
  logic [3:0]  count0_o;
  logic [3:0]  count1_o;

  int checks = 0;
  int errors = 0;

  stream_demux_1to2 #(.size(32), .DEPTH(2), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .select_i(select_i),
    .valid0_o(valid0_o), .ready0_i(ready0_i), .data0_o(data0_o),
    .valid1_o(valid1_o), .ready1_i(ready1_i), .data1_o(data1_o),
    .count0_o(count0_o), .count1_o(count1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; data_i = '0; select_i = 1'b0;
    ready0_i = 1'b0; ready1_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // reset / idle
    chk("idle_valid0", 32'(valid0_o), 32'd0);
    chk("idle_valid1", 32'(valid1_o), 32'd0);
    chk("idle_count0", 32'(count0_o), 32'd0);
    chk("idle_count1", 32'(count1_o), 32'd0);
    chk("idle_data0", data0_o, 32'd0);
    chk("idle_data1", data1_o, 32'd0);
    select_i = 1'b0; #1;
    chk("idle_ready_sel0", 32'(ready_o), 32'd1);
    select_i = 1'b1; #1;
    chk("idle_ready_sel1", 32'(ready_o), 32'd1);

    // single beat to channel 1, one-cycle latency
    valid_i = 1'b1; data_i = 32'hDEADBEEF; select_i = 1'b1; ready1_i = 1'b1; #1;
    chk("single_no_bypass", 32'(valid1_o), 32'd0);
    tick();
    valid_i = 1'b0;
    chk("single_valid1", 32'(valid1_o), 32'd1);
    chk("single_data1", data1_o, 32'hDEADBEEF);
    chk("single_valid0", 32'(valid0_o), 32'd0);
    chk("single_count1", 32'(count1_o), 32'd1);
    tick();
    chk("single_popped", 32'(valid1_o), 32'd0);

    // fill channel 0 with consumer stalled
    ready0_i = 1'b0; ready1_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'h11;
    tick();
    chk("fill_count0_1", 32'(count0_o), 32'd1);
    chk("fill_data0_11", data0_o, 32'h11);
    chk("fill_ready_after1", 32'(ready_o), 32'd1);
    data_i = 32'h22;
    tick();
    chk("fill_ready_after2", 32'(ready_o), 32'd0);
    chk("fill_count0_2", 32'(count0_o), 32'd2);

    // channel 1 stays open while channel 0 is full
    data_i = 32'h44; select_i = 1'b1; #1;
    chk("cross_ready_sel1", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("cross_valid1", 32'(valid1_o), 32'd1);
    chk("cross_data1", data1_o, 32'h44);
    chk("cross_count1", 32'(count1_o), 32'd2);
    chk("cross_data0_held", data0_o, 32'h11);
    chk("cross_count0", 32'(count0_o), 32'd2);
    ready1_i = 1'b1;
    tick();
    ready1_i = 1'b0;
    chk("cross_popped", 32'(valid1_o), 32'd0);

    // third beat stalls until channel 0 drains
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'h33; #1;
    chk("stall_ready", 32'(ready_o), 32'd0);
    tick();
    chk("stall_count0", 32'(count0_o), 32'd2);
    chk("stall_data0_held", data0_o, 32'h11);
    ready0_i = 1'b1;
    tick();
    chk("drain_data0_22", data0_o, 32'h22);
    chk("drain_count0_noacc", 32'(count0_o), 32'd2);
    chk("drain_ready_back", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("drain_data0_33", data0_o, 32'h33);
    chk("drain_count0_3", 32'(count0_o), 32'd3);
    tick();
    chk("drain_empty", 32'(valid0_o), 32'd0);

    // occupancy 1 with simultaneous push and pop, across pointer wrap
    ready0_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'h50;
    tick();
    chk("pp_head_50", data0_o, 32'h50);
    ready0_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_i = 32'h55 + 32'(i);
      tick();
      chk("pp_head", data0_o, 32'h55 + 32'(i));
      chk("pp_valid0", 32'(valid0_o), 32'd1);
    end
    valid_i = 1'b0;
    tick();
    chk("pp_drained", 32'(valid0_o), 32'd0);
    chk("pp_count0", 32'(count0_o), 32'd14);
    ready0_i = 1'b0;

    // asynchronous reset while both channels hold data
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA0;
    tick();
    select_i = 1'b1; data_i = 32'hA1;
    tick();
    valid_i = 1'b0;
    chk("prerst_valid0", 32'(valid0_o), 32'd1);
    chk("prerst_valid1", 32'(valid1_o), 32'd1);
    rst_i = 1'b0; #1;
    chk("rst_valid0", 32'(valid0_o), 32'd0);
    chk("rst_valid1", 32'(valid1_o), 32'd0);
    chk("rst_count0", 32'(count0_o), 32'd0);
    chk("rst_count1", 32'(count1_o), 32'd0);
    chk("rst_data0", data0_o, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    valid_i = 1'b1; select_i = 1'b1; data_i = 32'hB7; #1;
    chk("postrst_no_bypass", 32'(valid1_o), 32'd0);
    tick();
    valid_i = 1'b0;
    chk("postrst_valid1", 32'(valid1_o), 32'd1);
    chk("postrst_data1", data1_o, 32'hB7);
    chk("postrst_count1", 32'(count1_o), 32'd1);

    // counter wrap: 17 beats into channel 0
    ready0_i = 1'b1;
    valid_i = 1'b1; select_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      data_i = 32'h100 + 32'(i);
      tick();
      if (i == 15) chk("wrap_count0_16", 32'(count0_o), 32'd0);
    end
    valid_i = 1'b0;
    chk("wrap_count0_17", 32'(count0_o), 32'd1);
    chk("wrap_count1_still", 32'(count1_o), 32'd1);
    chk("wrap_last_head", data0_o, 32'h110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2-to-1 datapath select.
- Accepts one input stream with valid/ready handshake and a per-beat select bit, and steers each beat into one of two output channels.
- Each channel has a small in-order FIFO so a stalled consumer does not block the other channel once its beat is stored.
- Used between a shared producer (e.g. a writeback/result bus) and two downstream consumers.

Parameters:
- size, 32: data width in bits (must be >= 1).
- DEPTH, 2: entries per output FIFO; power of 2, >= 2.
- CNT_W, 16: width of the per-channel accepted-beat counters.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat can be accepted this cycle.
- data_i  input  size  input beat data.
- select_i  input  1  destination of the beat: 0 -> channel 0, 1 -> channel 1; sampled with data_i.
- valid0_o  output  1  channel 0 has a beat.
- ready0_i  input  1  channel 0 consumer ready.
- data0_o  output  size  channel 0 head data.
- valid1_o  output  1  channel 1 has a beat.
- ready1_i  input  1  channel 1 consumer ready.
- data1_o  output  size  channel 1 head data.
- count0_o  output  CNT_W  beats accepted into channel 0 since reset.
- count1_o  output  CNT_W  beats accepted into channel 1 since reset.

Behaviour:
- Reset (rst_i low, asynchronous): both FIFOs empty, read/write pointers 0, valid0_o = valid1_o = 0, data0_o = data1_o = 0, count0_o = count1_o = 0. Reset mid-transfer discards all stored beats. No beat is accepted while rst_i is low.
- ready_o = NOT full[select_i]. It is combinational from select_i and FIFO state only, with no path from ready0_i or ready1_i.
- Accept: valid_i AND ready_o. The beat is written to the FIFO of select_i at the rising edge.
- Latency: an accepted beat into an empty FIFO appears on validN_o/dataN_o in the next cycle (1-cycle latency). There is no same-cycle bypass.
- Output: validN_o = NOT empty[N]; dataN_o = head entry of FIFO N. dataN_o holds its value while validN_o is 1 and readyN_i is 0.
- Pop: validN_o AND readyN_i advances FIFO N at the rising edge.
- Push and pop on the same FIFO in the same cycle:
  - FIFO not full: occupancy unchanged, order preserved.
  - FIFO full: push is blocked (ready_o = 0) and only the pop occurs; ready_o rises in the next cycle.
- Push into one channel while the other channel pops is fully independent.
- Ordering is FIFO within each channel. There is no ordering guarantee across channels.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits. Full when occupancy = DEPTH; empty when occupancy = 0.
- countN_o increments by 1 on each accept into channel N and wraps to 0 after 2^CNT_W - 1. It never changes on pop.
- valid_i high with ready_o low: no state change. The producer must hold data_i/select_i stable until accepted; the block does not check this.
- When valid_i = 0, select_i and data_i are ignored, but ready_o still reflects full[select_i].
- Outputs are driven only from registers (FIFO storage, pointers, counters), except ready_o.

Test Plan:
- Reset then idle -> valid0_o = valid1_o = 0, count0_o = count1_o = 0, ready_o = 1 for both select_i values.
- Single beat data_i = 0xDEADBEEF, select_i = 1, ready1_i = 1 -> valid1_o = 1 with data1_o = 0xDEADBEEF exactly one cycle after accept. Channel 0 stays invalid. count1_o = 1.
- ready0_i = 0; push 0x11, 0x22, 0x33 to channel 0 (DEPTH = 2):
  - ready_o drops after the second accept; the third beat stalls.
  - Raise ready0_i -> outputs 0x11, 0x22, 0x33 in order, and the third beat is accepted the cycle after the first pop.
- Channel 0 full and stalled; push 0x44 with select_i = 1 -> accepted immediately and appears on channel 1 while channel 0 is unchanged.
- Occupancy 1, simultaneous push 0x55 and pop -> occupancy stays 1, the next head is 0x55. Run 10 such beats to exercise pointer wrap; data order stays correct.
- Assert rst_i low while both FIFOs hold data -> valid outputs and counters clear immediately (asynchronously). After release, a new beat flows with 1-cycle latency.
- CNT_W = 4: accept 17 beats to channel 0 -> count0_o = 1 after the wrap.
